// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch controller.
//   fetch_state_e    : controller FSM states (BOOT, RUN, HALT)
//   RESET_PC_DEFAULT : default PC loaded on reset, also the first fetch address
//   PC_INC           : PC advance per completed fetch (one 32-bit instruction)
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_stage_reg.sv
// ---------------------------------------------------------------------------
// fetch_stage_reg
// One pipeline stage register holding a PC and its valid bit.
// Control priority: reset > clear > load > hold.
//   clear drops the valid bit only; the PC value is kept so the stage still
//   shows the last address it carried.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   i_load       : capture i_pc / i_valid
//   i_clear      : drop o_valid, keep o_pc
//   i_pc, i_valid: incoming PC and valid from the previous stage
//   o_pc, o_valid: registered stage contents
// ---------------------------------------------------------------------------
module fetch_stage_reg #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_pc,
    input  logic        i_valid,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic        r_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_valid <= i_valid;
        end
    end

    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Program counter sequencer and F/D/E PC pipeline for the RISC-V core.
//
// Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN
//   defined   : a redirect whose target is not word aligned sends the FSM to
//               HALT; trap is high while halted, only reset leaves HALT.
//   undefined : no alignment check, trap tied low, HALT unreachable.
//
// Instruction memory handshake: imem_req is the request-valid and imem_ready
// the ready. A fetch of imem_addr completes in any cycle where imem_req and
// imem_ready are both high and no redirect or stall is present. While waiting,
// imem_addr is held stable unless a redirect arrives, in which case the
// outstanding request is abandoned and the new address is presented the next
// cycle.
//
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   redirect_valid    : execute redirects the PC this cycle
//   redirect_target   : redirect address
//   stall             : downstream hazard, freeze F/D/E
//   imem_ready        : memory returns data for imem_addr this cycle
//   imem_req          : fetch request valid
//   imem_addr         : fetch address (= pc_F)
//   pc_F, pc_D, pc_E  : per-stage PC
//   valid_D, valid_E  : stage holds a real instruction
//   flush             : combinational, high when a redirect is accepted
//   trap              : misaligned redirect halted the fetch unit
//   state_dbg         : current FSM state for observation
// ---------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_target,
    input  logic         stall,
    input  logic         imem_ready,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    output logic [31:0]  pc_F,
    output logic [31:0]  pc_D,
    output logic [31:0]  pc_E,
    output logic         valid_D,
    output logic         valid_E,
    output logic         flush,
    output logic         trap,
    output fetch_state_e state_dbg
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc_f;
    logic [31:0]  w_pc_f_next;

    logic         w_d_load;
    logic         w_d_clear;
    logic         w_e_load;
    logic         w_e_clear;
    logic         w_flush;
    logic         w_imem_req;

    logic [31:0]  w_pc_d;
    logic [31:0]  w_pc_e;
    logic         w_valid_d;
    logic         w_valid_e;

    // State and fetch PC registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= BOOT;
            r_pc_f  <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc_f  <= w_pc_f_next;
        end
    end

    // Next state and per-cycle event priority: redirect > stall > fetch > wait
    always_comb begin
        w_state_next = r_state;
        w_pc_f_next  = r_pc_f;
        w_d_load     = 1'b0;
        w_d_clear    = 1'b0;
        w_e_load     = 1'b0;
        w_e_clear    = 1'b0;
        w_flush      = 1'b0;
        w_imem_req   = 1'b0;

        case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end

            RUN: begin
                w_imem_req = 1'b1;
                if (redirect_valid) begin
                    // Redirect overrides stall and imem_ready; D/E keep their
                    // PCs but lose their valid bits.
                    w_flush     = 1'b1;
                    w_pc_f_next = redirect_target;
                    w_d_clear   = 1'b1;
                    w_e_clear   = 1'b1;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
                    if (redirect_target[1:0] != 2'b00) begin
                        w_state_next = HALT;
                    end
`endif
                end else if (stall) begin
                    // Everything holds; the request stays asserted.
                    w_pc_f_next = r_pc_f;
                end else if (imem_ready) begin
                    w_pc_f_next = r_pc_f + PC_INC;
                    w_d_load    = 1'b1;
                    w_e_load    = 1'b1;
                end else begin
                    // Memory wait: a bubble enters D, E still advances.
                    w_d_clear = 1'b1;
                    w_e_load  = 1'b1;
                end
            end

            HALT: begin
                w_state_next = HALT;
            end

            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    fetch_stage_reg #(
        .RESET_PC (RESET_PC)
    ) u_stage_d (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_d_load),
        .i_clear (w_d_clear),
        .i_pc    (r_pc_f),
        .i_valid (1'b1),
        .o_pc    (w_pc_d),
        .o_valid (w_valid_d)
    );

    fetch_stage_reg #(
        .RESET_PC (RESET_PC)
    ) u_stage_e (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_e_load),
        .i_clear (w_e_clear),
        .i_pc    (w_pc_d),
        .i_valid (w_valid_d),
        .o_pc    (w_pc_e),
        .o_valid (w_valid_e)
    );

    assign imem_req  = w_imem_req;
    assign imem_addr = r_pc_f;
    assign pc_F      = r_pc_f;
    assign pc_D      = w_pc_d;
    assign pc_E      = w_pc_e;
    assign valid_D   = w_valid_d;
    assign valid_E   = w_valid_e;
    assign flush     = w_flush;
    assign state_dbg = r_state;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    assign trap = (r_state == HALT);
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. Each task drives one scenario and checks the
// hand-computed pipeline contents after each rising edge (sampled 1 ns later).
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0100_0000;

    logic         clock;
    logic         reset;
    logic         redirect_valid;
    logic [31:0]  redirect_target;
    logic         stall;
    logic         imem_ready;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic [31:0]  pc_F;
    logic [31:0]  pc_D;
    logic [31:0]  pc_E;
    logic         valid_D;
    logic         valid_E;
    logic         flush;
    logic         trap;
    fetch_state_e state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl #(
        .RESET_PC (RPC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_ready      (imem_ready),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .pc_F            (pc_F),
        .pc_D            (pc_D),
        .pc_E            (pc_E),
        .valid_D         (valid_D),
        .valid_E         (valid_E),
        .flush           (flush),
        .trap            (trap),
        .state_dbg       (state_dbg)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle 1 ns before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        stall = 1'b0; imem_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (state_dbg !== BOOT) begin n_err++; $display("FAIL rst_state: got %0d exp %0d", state_dbg, BOOT); end
        n_cmp++; if (pc_F !== RPC) begin n_err++; $display("FAIL rst_pc_F: got %h exp %h", pc_F, RPC); end
        n_cmp++; if (pc_D !== RPC) begin n_err++; $display("FAIL rst_pc_D: got %h exp %h", pc_D, RPC); end
        n_cmp++; if (pc_E !== RPC) begin n_err++; $display("FAIL rst_pc_E: got %h exp %h", pc_E, RPC); end
        n_cmp++; if ({valid_D, valid_E} !== 2'b00) begin n_err++; $display("FAIL rst_valid: got %b exp 00", {valid_D, valid_E}); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        n_cmp++; if (trap !== 1'b0) begin n_err++; $display("FAIL rst_trap: got %b exp 0", trap); end
        reset = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req: got %b exp 0", imem_req); end
        tick();
        n_cmp++; if (state_dbg !== RUN) begin n_err++; $display("FAIL run_state: got %0d exp %0d", state_dbg, RUN); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL run_req: got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0100_0000) begin n_err++; $display("FAIL addr0: got %h exp 01000000", imem_addr); end
        n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL vD0: got %b exp 0", valid_D); end
        tick();
        n_cmp++; if (imem_addr !== 32'h0100_0004) begin n_err++; $display("FAIL addr1: got %h exp 01000004", imem_addr); end
        n_cmp++; if (pc_D !== 32'h0100_0000 || valid_D !== 1'b1) begin n_err++; $display("FAIL d1: got %h/%b exp 01000000/1", pc_D, valid_D); end
        n_cmp++; if (valid_E !== 1'b0) begin n_err++; $display("FAIL vE1: got %b exp 0", valid_E); end
        tick();
        n_cmp++; if (imem_addr !== 32'h0100_0008) begin n_err++; $display("FAIL addr2: got %h exp 01000008", imem_addr); end
        n_cmp++; if (pc_D !== 32'h0100_0004) begin n_err++; $display("FAIL d2: got %h exp 01000004", pc_D); end
        n_cmp++; if (pc_E !== 32'h0100_0000 || valid_E !== 1'b1) begin n_err++; $display("FAIL e2: got %h/%b exp 01000000/1", pc_E, valid_E); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_target = 32'h0100_0100;
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL redir_flush: got %b exp 1", flush); end
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0100) begin n_err++; $display("FAIL redir_pcF: got %h exp 01000100", pc_F); end
        n_cmp++; if ({valid_D, valid_E} !== 2'b00) begin n_err++; $display("FAIL redir_valid: got %b exp 00", {valid_D, valid_E}); end
        n_cmp++; if (pc_D !== 32'h0100_0004 || pc_E !== 32'h0100_0000) begin n_err++; $display("FAIL redir_hold: got %h/%h exp 01000004/01000000", pc_D, pc_E); end
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL redir_flush_off: got %b exp 0", flush); end
        tick();
        n_cmp++; if (pc_D !== 32'h0100_0100 || valid_D !== 1'b1) begin n_err++; $display("FAIL redir_d: got %h/%b exp 01000100/1", pc_D, valid_D); end
        n_cmp++; if (pc_F !== 32'h0100_0104 || valid_E !== 1'b0) begin n_err++; $display("FAIL redir_f: got %h/%b exp 01000104/0", pc_F, valid_E); end
        tick();
        n_cmp++; if (pc_E !== 32'h0100_0100 || valid_E !== 1'b1) begin n_err++; $display("FAIL redir_e: got %h/%b exp 01000100/1", pc_E, valid_E); end
    endtask

    task automatic test_mem_wait();
        redirect_valid = 1'b1; redirect_target = 32'h0100_0008;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (pc_F !== 32'h0100_0010 || pc_D !== 32'h0100_000C || pc_E !== 32'h0100_0008) begin
            n_err++; $display("FAIL wait_pre: got %h/%h/%h exp 01000010/0100000c/01000008", pc_F, pc_D, pc_E); end
        imem_ready = 1'b0;
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0010 || valid_D !== 1'b0 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL wait1_f: got %h/%b/%b exp 01000010/0/1", pc_F, valid_D, imem_req); end
        n_cmp++; if (pc_E !== 32'h0100_000C || valid_E !== 1'b1) begin n_err++; $display("FAIL wait1_e: got %h/%b exp 0100000c/1", pc_E, valid_E); end
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0010 || {valid_D, valid_E} !== 2'b00) begin
            n_err++; $display("FAIL wait2: got %h/%b exp 01000010/00", pc_F, {valid_D, valid_E}); end
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0010 || {valid_D, valid_E} !== 2'b00) begin
            n_err++; $display("FAIL wait3: got %h/%b exp 01000010/00", pc_F, {valid_D, valid_E}); end
        imem_ready = 1'b1;
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0014 || pc_D !== 32'h0100_0010 || valid_D !== 1'b1 || valid_E !== 1'b0) begin
            n_err++; $display("FAIL resume1: got %h/%h/%b/%b exp 01000014/01000010/1/0", pc_F, pc_D, valid_D, valid_E); end
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0018 || pc_E !== 32'h0100_0010 || valid_E !== 1'b1) begin
            n_err++; $display("FAIL resume2: got %h/%h/%b exp 01000018/01000010/1", pc_F, pc_E, valid_E); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0018 || pc_D !== 32'h0100_0014 || pc_E !== 32'h0100_0010) begin
            n_err++; $display("FAIL stall1_pc: got %h/%h/%h exp 01000018/01000014/01000010", pc_F, pc_D, pc_E); end
        n_cmp++; if ({valid_D, valid_E} !== 2'b11 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL stall1_v: got %b/%b exp 11/1", {valid_D, valid_E}, imem_req); end
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0018 || pc_D !== 32'h0100_0014 || {valid_D, valid_E} !== 2'b11) begin
            n_err++; $display("FAIL stall2: got %h/%h/%b exp 01000018/01000014/11", pc_F, pc_D, {valid_D, valid_E}); end
        redirect_valid = 1'b1; redirect_target = 32'h0100_0200;
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL stall_redir_flush: got %b exp 1", flush); end
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0200 || {valid_D, valid_E} !== 2'b00 || pc_D !== 32'h0100_0014) begin
            n_err++; $display("FAIL stall_redir: got %h/%b/%h exp 01000200/00/01000014", pc_F, {valid_D, valid_E}, pc_D); end
        redirect_valid = 1'b0;
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0200 || valid_D !== 1'b0) begin n_err++; $display("FAIL post_redir_stall: got %h/%b exp 01000200/0", pc_F, valid_D); end
        stall = 1'b0;
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0204 || pc_D !== 32'h0100_0200 || valid_D !== 1'b1) begin
            n_err++; $display("FAIL post_stall: got %h/%h/%b exp 01000204/01000200/1", pc_F, pc_D, valid_D); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        n_cmp++; if (pc_F !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pre: got %h exp fffffffc", pc_F); end
        redirect_valid = 1'b0;
        tick();
        n_cmp++; if (pc_F !== 32'h0000_0000 || pc_D !== 32'hFFFF_FFFC || valid_D !== 1'b1) begin
            n_err++; $display("FAIL wrap: got %h/%h/%b exp 00000000/fffffffc/1", pc_F, pc_D, valid_D); end
        n_cmp++; if (pc_E !== 32'h0100_0200 || valid_E !== 1'b0) begin n_err++; $display("FAIL wrap_e: got %h/%b exp 01000200/0", pc_E, valid_E); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_target = 32'h0100_0102;
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL mis_flush: got %b exp 1", flush); end
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        n_cmp++; if (state_dbg !== HALT || trap !== 1'b1 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL mis_halt: got %0d/%b/%b exp %0d/1/0", state_dbg, trap, imem_req, HALT); end
        n_cmp++; if (pc_F !== 32'h0100_0102 || {valid_D, valid_E} !== 2'b00) begin
            n_err++; $display("FAIL mis_pc: got %h/%b exp 01000102/00", pc_F, {valid_D, valid_E}); end
        redirect_valid = 1'b1; redirect_target = 32'h0100_0400;
        tick(); tick();
        redirect_valid = 1'b0;
        n_cmp++; if (state_dbg !== HALT || trap !== 1'b1 || imem_req !== 1'b0 || pc_F !== 32'h0100_0102) begin
            n_err++; $display("FAIL halt_hold: got %0d/%b/%b/%h exp %0d/1/0/01000102", state_dbg, trap, imem_req, pc_F, HALT); end
`else
        n_cmp++; if (state_dbg !== RUN || trap !== 1'b0 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL mis_run: got %0d/%b/%b exp %0d/0/1", state_dbg, trap, imem_req, RUN); end
        n_cmp++; if (pc_F !== 32'h0100_0102) begin n_err++; $display("FAIL mis_pc: got %h exp 01000102", pc_F); end
        tick();
        n_cmp++; if (pc_F !== 32'h0100_0106 || pc_D !== 32'h0100_0102 || valid_D !== 1'b1) begin
            n_err++; $display("FAIL mis_adv: got %h/%h/%b exp 01000106/01000102/1", pc_F, pc_D, valid_D); end
`endif
    endtask

    task automatic test_reset_mid();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0100_0300; reset = 1'b1;
        tick();
        n_cmp++; if (state_dbg !== BOOT || trap !== 1'b0 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_st: got %0d/%b/%b exp %0d/0/0", state_dbg, trap, imem_req, BOOT); end
        n_cmp++; if (pc_F !== RPC || pc_D !== RPC || pc_E !== RPC || {valid_D, valid_E} !== 2'b00) begin
            n_err++; $display("FAIL mid_rst_pc: got %h/%h/%h/%b exp %h x3/00", pc_F, pc_D, pc_E, {valid_D, valid_E}, RPC); end
        reset = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b1;
        tick();
        n_cmp++; if (state_dbg !== RUN || imem_addr !== RPC || imem_req !== 1'b1) begin
            n_err++; $display("FAIL mid_rst_run: got %0d/%h/%b exp %0d/%h/1", state_dbg, imem_addr, imem_req, RUN, RPC); end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_mem_wait();
        test_stall();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
